eth_tx_arbiter: RTL
===================

# eth_tx_arbiter

Parametrised N-channel transmit arbiter for the GMII Ethernet path. It sits between the protocol transmit engines (ARP, ICMP, UDP and later additions) and the single GMII transmit port. It replaces fixed three-way protocol switching with request latching, frame-atomic grants and selectable fixed-priority or round-robin arbitration. It also enforces a programmable inter-frame gap, aborts stalled engines on a timeout, and routes the shared payload-FIFO read port to the granted channel.

## Interface
- NUM_CH, 3, number of transmit channels (2..8); channel 0 = ARP by convention
- DATA_W, 8, GMII data width
- TIMEOUT_W, 24, grant watchdog counter width; timeout after 2^TIMEOUT_W-1 cycles
- IFG_CYCLES, 12, idle cycles forced on GMII after every frame or abort (0 allowed)

- clk  in  1  GMII transmit clock, 125 MHz
- rst_n  in  1  synchronous, active-low reset
- ch_start  in  NUM_CH  per-channel frame request pulse (1 cycle)
- ch_done  in  NUM_CH  per-channel frame-complete pulse
- ch_tx_en  in  NUM_CH  per-channel GMII enable
- ch_txd  in  NUM_CH*DATA_W  per-channel GMII data; channel i occupies bits [i*DATA_W +: DATA_W]
- ch_grant  out  NUM_CH  one-hot grant; all-zero when idle
- ch_fifo_req  in  NUM_CH  per-channel payload-FIFO read request
- fifo_rd_req  out  1  shared FIFO read request
- fifo_rd_data  in  DATA_W  shared FIFO read data, valid 1 cycle after fifo_rd_req
- ch_fifo_data  out  DATA_W  FIFO data returned to the granted channel; zero otherwise
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  1-cycle pulse on watchdog abort
- gmii_tx_en  out  1  registered GMII enable
- gmii_txd  out  DATA_W  registered GMII data

## Operation
- Pending register `pend[NUM_CH]`:
  - set by `ch_start[i]`;
  - cleared when channel i is granted, or on its abort;
  - a start while already pending is idempotent;
  - a start from the currently granted channel sets pend again, so that channel queues its next frame.
- FSM states: IDLE, GRANT, SEND, IFG.
  - IDLE: if pend is nonzero, select a winner, load ch_grant and go to GRANT.
  - GRANT: waits for `ch_tx_en` of the winner and then goes to SEND. A `ch_done` of the winner arriving here goes directly to IFG.
  - SEND: `ch_done` of the winner goes to IFG.
  - IFG: counts IFG_CYCLES with grant cleared, then goes to IDLE. With IFG_CYCLES=0, IFG lasts 1 cycle.
- Watchdog:
  - counter cleared on entry to GRANT and increments in GRANT and SEND;
  - when the counter reaches all-ones: pulse timeout_err, clear ch_grant and go to IFG;
  - the engine's later ch_done is ignored.
- GMII mux:
  - next-cycle gmii_tx_en/gmii_txd = granted channel's ch_tx_en/ch_txd in GRANT/SEND;
  - 0 / 0 in IDLE and IFG.
  - ch_tx_en from non-granted channels is ignored and never reaches GMII.
- FIFO routing:
  - fifo_rd_req = ch_fifo_req of the granted channel (combinational AND with ch_grant);
  - ch_fifo_data = fifo_rd_data when the registered fifo_rd_req is high, else 0.
  - Requests from non-granted channels are ignored.
- A grant is never changed mid-frame, whatever new requests arrive.

## Timing
- Reset values: ch_grant=0, busy=0, timeout_err=0, gmii_tx_en=0, gmii_txd=0, ch_fifo_data=0, pend=0, FSM=IDLE, counters=0.
- ch_start at cycle t, arbiter IDLE with no other pending request: pend set at t+1, ch_grant at t+2.
- Data path latency: ch_txd/ch_tx_en to gmii_txd/gmii_tx_en is 1 cycle.
- ch_done at cycle t: ch_grant=0 at t+1; first re-grant at t+1+IFG_CYCLES+1 at the earliest.
- Simultaneous ch_start and ch_done of the same channel: the frame ends and the new request stays pending.
- rst_n low mid-frame: all outputs return to reset values on the next clk edge; pending requests are lost.

## Configuration
- ETH_ARB_RR_EN defined: round-robin arbitration. The search starts at the channel after the last granted one and wraps from NUM_CH-1 to 0. After reset the last-granted pointer is NUM_CH-1, so channel 0 is checked first.
- Not defined: fixed priority, lowest index wins (ARP highest). No pointer register is implemented.

## Test plan
- Single request: ch_start[2] pulse, engine drives ch_tx_en for 64 cycles then ch_done -> ch_grant=3'b100, 64 bytes on GMII each delayed 1 cycle, 12 idle cycles, busy falls.
- Contention: ch_start[0..2] in the same cycle, all pending. Fixed priority -> grant order 0,1,2. With ETH_ARB_RR_EN and requests re-issued every frame -> order 0,1,2,0,1,2.
- Mid-frame intrusion: ch_start[0] during channel 1 SEND -> channel 1 finishes uninterrupted; channel 0 is granted after the IFG; GMII never shows channel-0 data during channel 1's frame.
- Watchdog: TIMEOUT_W=4, grant channel 1 with no ch_tx_en -> timeout_err pulse after 15 cycles, grant drops, a later ch_done[1] has no effect.
- FIFO routing: channel 1 granted, ch_fifo_req[1] and ch_fifo_req[2] high -> fifo_rd_req=1; ch_fifo_data carries fifo_rd_data one cycle later, and channel 2's request is ignored.
- Reset mid-SEND: rst_n low for 1 cycle -> all outputs 0 next cycle and pend cleared.

Source files
------------

// File: rtl/eth_tx_arbiter.sv
// N-channel GMII transmit arbiter: frame-atomic grants, forced inter-frame gap, grant watchdog,
// shared payload-FIFO routing. Define ETH_ARB_RR_EN for round-robin; default is fixed priority.
//
// state | meaning
// IDLE  | no grant; picks a winner as soon as any request is pending
// GRANT | winner granted, waiting for its first ch_tx_en
// SEND  | frame in progress until the winner's ch_done
// IFG   | grant cleared, GMII held idle for the gap
module eth_tx_arbiter #(
  parameter int NUM_CH     = 3,
  parameter int DATA_W     = 8,
  parameter int TIMEOUT_W  = 24,
  parameter int IFG_CYCLES = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        ch_start,
  input  logic [NUM_CH-1:0]        ch_done,
  input  logic [NUM_CH-1:0]        ch_tx_en,
  input  logic [NUM_CH*DATA_W-1:0] ch_txd,
  output logic [NUM_CH-1:0]        ch_grant,
  input  logic [NUM_CH-1:0]        ch_fifo_req,
  output logic                     fifo_rd_req,
  input  logic [DATA_W-1:0]        fifo_rd_data,
  output logic [DATA_W-1:0]        ch_fifo_data,
  output logic                     busy,
  output logic                     timeout_err,
  output logic                     gmii_tx_en,
  output logic [DATA_W-1:0]        gmii_txd
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  // A zero-length gap still spends one cycle in IFG.
  localparam logic [IFG_W-1:0] IFG_LOAD = IFG_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_SEND, S_IFG} state_t;

  state_t                 state_q, state_d;
  logic [NUM_CH-1:0]      grant_q, grant_d;
  logic [NUM_CH-1:0]      pend_q, pend_clr;
  logic [TIMEOUT_W-1:0]   wd_q, wd_d;
  logic [IFG_W-1:0]       ifg_q, ifg_d;
  logic                   fifo_req_q;
  logic [NUM_CH-1:0]      win_oh;
  logic                   active;
  logic                   sel_en;
  logic [DATA_W-1:0]      sel_txd;

`ifdef ETH_ARB_RR_EN
  logic [CH_W-1:0] last_q;
  logic [CH_W-1:0] win_idx;
  logic [CH_W-1:0] cand_idx;
  int              cand;

  // Walk from farthest to nearest so the channel right after last_q wins.
  always_comb begin
    win_oh   = '0;
    win_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      cand = int'(last_q) + k;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      cand_idx = CH_W'(cand);
      if (pend_q[cand_idx]) begin
        win_idx = cand_idx;
        win_oh  = NUM_CH'(1) << cand_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) last_q <= CH_W'(NUM_CH - 1);
    else if (state_q == S_IDLE && |pend_q) last_q <= win_idx;
  end
`else
  always_comb begin
    win_oh = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        win_oh    = '0;
        win_oh[i] = 1'b1;
      end
    end
  end
`endif

  assign active = (state_q == S_GRANT) || (state_q == S_SEND);

  always_comb begin
    sel_en  = |(ch_tx_en & grant_q);
    sel_txd = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel_txd = sel_txd | (ch_txd[i*DATA_W +: DATA_W] & {DATA_W{grant_q[i]}});
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    wd_d        = wd_q;
    ifg_d       = ifg_q;
    pend_clr    = '0;
    timeout_err = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|pend_q) begin
          grant_d  = win_oh;
          pend_clr = win_oh;
          wd_d     = '0;
          state_d  = S_GRANT;
        end
      end
      S_GRANT, S_SEND: begin
        wd_d = wd_q + 1'b1;
        if (&wd_q) begin
          timeout_err = 1'b1;
          pend_clr    = grant_q;
          grant_d     = '0;
          ifg_d       = IFG_LOAD;
          state_d     = S_IFG;
        end else if (|(ch_done & grant_q)) begin
          grant_d = '0;
          ifg_d   = IFG_LOAD;
          state_d = S_IFG;
        end else if (state_q == S_GRANT && sel_en) begin
          state_d = S_SEND;
        end
      end
      S_IFG: begin
        if (ifg_q == '0) state_d = S_IDLE;
        else             ifg_d   = ifg_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      pend_q     <= '0;
      wd_q       <= '0;
      ifg_q      <= '0;
      fifo_req_q <= 1'b0;
      gmii_tx_en <= 1'b0;
      gmii_txd   <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      pend_q     <= (pend_q & ~pend_clr) | ch_start;
      wd_q       <= wd_d;
      ifg_q      <= ifg_d;
      fifo_req_q <= fifo_rd_req;
      gmii_tx_en <= active & sel_en;
      gmii_txd   <= active ? sel_txd : '0;
    end
  end

  assign ch_grant     = grant_q;
  assign busy         = (state_q != S_IDLE);
  assign fifo_rd_req  = |(ch_fifo_req & grant_q);
  assign ch_fifo_data = fifo_req_q ? fifo_rd_data : '0;

endmodule
